// File: rtl/uart_program_loader.sv
// Purpose: receives a program frame over UART RXD and writes 32-bit words into instruction memory, holding the core in reset until the checksum verifies.
// Latency: a byte is delivered 1 cycle after its stop-bit sample; mem_wr_en follows 1 cycle after a word's fourth byte.
// Backpressure: none; MEM accepts a write every cycle, and the receiver rearms at once so back-to-back bytes are accepted.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  RXD,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       SYNC_BYTE = 8'h55;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {IDLE, GET_LEN, GET_DATA, GET_CHK} frm_state_t;

    // ---------------- RX front end ----------------
    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;
    rx_state_t        rx_state_q;
    rx_state_t        rx_state_d;
    logic             rx_tick;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_byte_vld;
    logic             rx_frame_err;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Receiver state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_state_q <= RX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    // Receiver next state; rx_tick marks the cycle a bit is sampled.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev && !rxd_sync) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_tick    = 1'b1;
                    // A start bit that is high again by mid-bit was a glitch.
                    rx_state_d = rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_tick = 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_tick    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Bit timing counters, LSB-first shift register and the byte/framing-error strobes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_byte_vld  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_byte_vld  <= 1'b0;
            rx_frame_err <= 1'b0;
            if (rx_state_q == RX_IDLE || rx_tick) begin
                rx_cnt_q <= '0;
            end else begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end
            if (rx_state_q == RX_IDLE) begin
                rx_bit_q <= '0;
            end
            if (rx_tick) begin
                unique case (rx_state_q)
                    RX_DATA: begin
                        rx_shift_q <= {rxd_sync, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                    end
                    RX_STOP: begin
                        if (rxd_sync) begin
                            rx_byte_vld <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- Frame parser ----------------
    frm_state_t            frm_state_q;
    frm_state_t            frm_state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            byte_idx_q;
    logic [8:0]            n_words_q;
    logic [8:0]            word_cnt_q;
    logic [23:0]           word_q;
    logic [7:0]            chk_q;
    logic                  last_byte;
    logic                  last_word;

    assign mem_wr_addr = addr_q;
    assign last_byte   = (byte_idx_q == 2'd3);
    assign last_word   = ((word_cnt_q + 9'd1) == n_words_q);

    // Frame state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            frm_state_q <= IDLE;
        end else begin
            frm_state_q <= frm_state_d;
        end
    end

    // Frame next state: a framing error always aborts to IDLE; sync is only honoured in IDLE.
    always_comb begin
        frm_state_d = frm_state_q;
        if (rx_frame_err) begin
            frm_state_d = IDLE;
        end else if (rx_byte_vld) begin
            unique case (frm_state_q)
                IDLE: begin
                    if (rx_shift_q == SYNC_BYTE) begin
                        frm_state_d = GET_LEN;
                    end
                end
                GET_LEN:  frm_state_d = GET_DATA;
                GET_DATA: begin
                    if (last_byte && last_word) begin
                        frm_state_d = GET_CHK;
                    end
                end
                GET_CHK:  frm_state_d = IDLE;
                default:  frm_state_d = IDLE;
            endcase
        end
    end

    // Word assembly, checksum, MEM write strobe and the hold/done/error outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q      <= '0;
            byte_idx_q  <= '0;
            n_words_q   <= '0;
            word_cnt_q  <= '0;
            word_q      <= '0;
            chk_q       <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            cpu_hold    <= 1'b0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            load_done <= 1'b0;
            // Address advances after each write and wraps naturally at 2^ADDR_WIDTH.
            if (mem_wr_en) begin
                addr_q <= addr_q + 1'b1;
            end
            if (rx_frame_err) begin
                if (frm_state_q != IDLE) begin
                    load_error <= 1'b1;
                end
            end else if (rx_byte_vld) begin
                unique case (frm_state_q)
                    IDLE: begin
                        if (rx_shift_q == SYNC_BYTE) begin
                            cpu_hold   <= 1'b1;
                            load_error <= 1'b0;
                            addr_q     <= '0;
                            byte_idx_q <= '0;
                            word_cnt_q <= '0;
                            chk_q      <= '0;
                        end
                    end
                    GET_LEN: begin
                        n_words_q <= (rx_shift_q == 8'h00) ? 9'd256 : {1'b0, rx_shift_q};
                    end
                    GET_DATA: begin
                        chk_q      <= chk_q ^ rx_shift_q;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        unique case (byte_idx_q)
                            2'd0: word_q[7:0]   <= rx_shift_q;
                            2'd1: word_q[15:8]  <= rx_shift_q;
                            2'd2: word_q[23:16] <= rx_shift_q;
                            default: begin
                                mem_wr_en   <= 1'b1;
                                mem_wr_data <= {rx_shift_q, word_q};
                                word_cnt_q  <= word_cnt_q + 9'd1;
                            end
                        endcase
                    end
                    GET_CHK: begin
                        if (rx_shift_q == chk_q) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: a vector table of whole frames plus
// hand-written sequences for glitches, reset mid-frame and a full 256-word load.
module tb_uart_program_loader;

    localparam int CPB = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RXD;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .RXD        (RXD),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 CLK = ~CLK;

    // Write / done monitor sampled on the falling edge.
    int          wr_n = 0;
    int          done_n = 0;
    logic [7:0]  wr_a [0:299];
    logic [31:0] wr_d [0:299];
    logic        hold_at_done = 1'b1;

    always @(negedge CLK) begin
        if (mem_wr_en) begin
            if (wr_n < 300) begin
                wr_a[wr_n] = mem_wr_addr;
                wr_d[wr_n] = mem_wr_data;
            end
            wr_n++;
        end
        if (load_done) begin
            done_n++;
            hold_at_done = cpu_hold;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RXD = stop;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b1;
        repeat (gap) @(negedge CLK);
    endtask

    typedef struct {
        int               nb;
        logic [0:11][7:0] b;
        logic             bad_stop_last;
        int               exp_wr;
        logic [31:0]      exp_d0;
        logic [31:0]      exp_d1;
        int               exp_done;
        logic             exp_err;
        logic             exp_hold;
    } vec_t;

    vec_t vt [0:5];
    int   wb;
    int   db;
    int   bad;

    initial begin
        vt[0] = '{7,  {8'h55, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b0, 1, 32'h00000013, 32'h0, 1, 1'b0, 1'b0};
        vt[1] = '{11, {8'h55, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'hE0, 8'h00},
                  1'b0, 2, 32'h00100093, 32'h00100073, 1, 1'b0, 1'b0};
        vt[2] = '{11, {8'h55, 8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'hE1, 8'h00},
                  1'b0, 2, 32'h00100093, 32'h00100073, 0, 1'b1, 1'b1};
        vt[3] = '{9,  {8'hAA, 8'h12, 8'h55, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00},
                  1'b0, 1, 32'h00000001, 32'h0, 1, 1'b0, 1'b0};
        vt[4] = '{7,  {8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b1, 1, 32'h44332211, 32'h0, 0, 1'b1, 1'b1};
        vt[5] = '{7,  {8'h55, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b0, 1, 32'h12345678, 32'h0, 1, 1'b0, 1'b0};

        // Reset state
        RESET = 1'b0;
        RXD   = 1'b1;
        #1;
        check("rst_wr_en",  32'(mem_wr_en),   0);
        check("rst_addr",   32'(mem_wr_addr), 0);
        check("rst_data",   mem_wr_data,      0);
        check("rst_hold",   32'(cpu_hold),    0);
        check("rst_done",   32'(load_done),   0);
        check("rst_error",  32'(load_error),  0);
        repeat (5) @(negedge CLK);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        // Short low glitch in IDLE must not produce a byte or any state change
        RXD = 1'b0;
        repeat (2) @(negedge CLK);
        RXD = 1'b1;
        repeat (40) @(negedge CLK);
        check("glitch_wr",    32'(wr_n),       0);
        check("glitch_hold",  32'(cpu_hold),   0);
        check("glitch_error", 32'(load_error), 0);
        check("glitch_done",  32'(done_n),     0);

        // Frame table
        for (int v = 0; v < 6; v++) begin
            wb = wr_n;
            db = done_n;
            for (int i = 0; i < vt[v].nb; i++) begin
                if (i == vt[v].nb - 1) check($sformatf("v%0d_hold_mid", v), 32'(cpu_hold), 1);
                send_byte(vt[v].b[i], !(vt[v].bad_stop_last && (i == vt[v].nb - 1)), 2);
            end
            repeat (20) @(negedge CLK);
            check($sformatf("v%0d_wr_count", v), 32'(wr_n - wb), 32'(vt[v].exp_wr));
            if (vt[v].exp_wr > 0) begin
                check($sformatf("v%0d_addr0", v), 32'(wr_a[wb]), 0);
                check($sformatf("v%0d_data0", v), wr_d[wb], vt[v].exp_d0);
            end
            if (vt[v].exp_wr > 1) begin
                check($sformatf("v%0d_addr1", v), 32'(wr_a[wb+1]), 1);
                check($sformatf("v%0d_data1", v), wr_d[wb+1], vt[v].exp_d1);
            end
            check($sformatf("v%0d_done", v),  32'(done_n - db),  32'(vt[v].exp_done));
            check($sformatf("v%0d_error", v), 32'(load_error),   32'(vt[v].exp_err));
            check($sformatf("v%0d_hold", v),  32'(cpu_hold),     32'(vt[v].exp_hold));
            if (vt[v].exp_done > 0) check($sformatf("v%0d_hold_at_done", v), 32'(hold_at_done), 0);
        end

        // Reset asserted in the middle of GET_DATA
        wb = wr_n;
        db = done_n;
        send_byte(8'h55, 1'b1, 2);
        send_byte(8'h02, 1'b1, 2);
        send_byte(8'h11, 1'b1, 2);
        send_byte(8'h22, 1'b1, 2);
        send_byte(8'h33, 1'b1, 2);
        send_byte(8'h44, 1'b1, 2);
        send_byte(8'h55, 1'b1, 2);
        send_byte(8'h66, 1'b1, 2);
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b1;
        repeat (3 * CPB) @(negedge CLK);
        check("mid_hold_before_rst", 32'(cpu_hold), 1);
        check("mid_addr_before_rst", 32'(mem_wr_addr), 1);
        #2;
        RESET = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(mem_wr_en),   0);
        check("mid_rst_addr",  32'(mem_wr_addr), 0);
        check("mid_rst_data",  mem_wr_data,      0);
        check("mid_rst_hold",  32'(cpu_hold),    0);
        check("mid_rst_error", 32'(load_error),  0);
        RXD = 1'b1;
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        repeat (100) @(negedge CLK);
        check("mid_rst_writes", 32'(wr_n - wb), 1);
        send_byte(8'h55, 1'b1, 2);
        send_byte(8'h01, 1'b1, 2);
        send_byte(8'h78, 1'b1, 2);
        send_byte(8'h56, 1'b1, 2);
        send_byte(8'h34, 1'b1, 2);
        send_byte(8'h12, 1'b1, 2);
        send_byte(8'h08, 1'b1, 2);
        repeat (20) @(negedge CLK);
        check("after_rst_writes", 32'(wr_n - wb), 2);
        check("after_rst_addr",   32'(wr_a[wb+1]), 0);
        check("after_rst_data",   wr_d[wb+1], 32'h12345678);
        check("after_rst_done",   32'(done_n - db), 1);
        check("after_rst_hold",   32'(cpu_hold), 0);

        // Full 256-word frame, bytes sent back-to-back with no idle bits
        wb = wr_n;
        db = done_n;
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        for (int i = 0; i < 1024; i++) begin
            send_byte(8'hFF, 1'b1, 0);
        end
        send_byte(8'h00, 1'b1, 2);
        repeat (20) @(negedge CLK);
        check("big_wr_count", 32'(wr_n - wb), 256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (wb + i < 300) begin
                if (wr_a[wb+i] !== 8'(i) || wr_d[wb+i] !== 32'hFFFFFFFF) bad++;
            end
        end
        check("big_bad_writes", 32'(bad), 0);
        check("big_last_addr",  32'(wr_a[wb+255]), 255);
        check("big_addr_wrap",  32'(mem_wr_addr), 0);
        check("big_done",       32'(done_n - db), 1);
        check("big_error",      32'(load_error), 0);
        check("big_hold",       32'(cpu_hold), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
